shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one 32-bit combinational shift unit (logical left, logical right, arithmetic right) between two requesters. Requests arrive on valid/ready channels and are granted round-robin. Each result is captured in a single-entry output register and returned on one tagged response channel with backpressure. The block sits between the ALU-side issue logic and the shared shifter datapath.

## Interface
- N, 32, data width; only 32 is supported.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  2  per-requester request valid; bit i belongs to requester i.
- req_ready  out  2  per-requester grant/accept. Combinational from the current state and req_valid.
- req0_data, req1_data  in  N each  operand to shift.
- req0_shamt, req1_shamt  in  5 each  shift amount, 0 to 31.
- req0_op, req1_op  in  2 each  operation: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
- rsp_valid  out  1  response register holds a valid result.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  N  shifted result.
- rsp_id  out  1  index of the requester that produced rsp_data.
- grant_cnt0, grant_cnt1  out  16 each  saturating accepted-request counters. Present only under the configuration macro.

## Operation
- Two states. EMPTY: rsp_valid=0. FULL: rsp_valid=1.
- Slot free condition: free = !rsp_valid | rsp_ready.
- Arbitration:
  - With one valid requester and the slot free, that requester is granted.
  - With both valid, the requester not granted last time wins. last_id updates on every accept.
  - At most one req_ready bit is high in any cycle.
  - req_ready = 0 whenever the slot is not free.
- Accept: occurs when req_valid[i] & req_ready[i].
  - rsp_data is loaded with the shift of the winner's operands.
  - rsp_id is loaded with i.
  - State goes to FULL.
- Drain:
  - rsp_valid & rsp_ready with no accept in the same cycle: state goes to EMPTY.
  - rsp_data and rsp_id keep their last value.
- Simultaneous drain and accept: state stays FULL and the register is loaded with the new result. This gives full throughput of one result per cycle.
- Shift semantics:
  - SLL fills with zeros.
  - SRL fills with zeros.
  - SRA fills with operand bit 31.
  - Shift amount 0 returns the operand unchanged.
  - Op 11 returns the operand unchanged, ignoring shamt.
- Requester obligations: requester operands are sampled only on the accept edge. A requester must hold valid and its operands stable until accepted. The block does not check this.

## Timing
- Latency: accept at rising edge k → rsp_valid=1 with the result immediately after edge k (one cycle).
- Output behaviour while waiting: rsp_data and rsp_id are stable while rsp_valid=1 and rsp_ready=0.
- Reset values:
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - last_id=1, so requester 0 wins the first contention.
  - Counters = 0.
- Reset asserted mid-operation: a pending response is discarded immediately (asynchronously). No accept occurs while rst=1. req_ready=0 while rst=1.
- Back-to-back operation: with rsp_ready held high and both requesters valid, grants alternate 0,1,0,1,... one per cycle.

## Configuration
- SHIFT_ARB_GRANT_COUNT_EN defined:
  - grant_cnt0 and grant_cnt1 exist.
  - Each counter increments on every accept for its requester and saturates at 0xFFFF.
  - Both counters reset to 0.
- SHIFT_ARB_GRANT_COUNT_EN undefined: the counter ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset, then idle: after releasing rst → rsp_valid=0, rsp_data=0, req_ready=00.
- Single request: requester 0 sends SLL, data 0x0000_0001, shamt 4, rsp_ready=1 → req_ready=01. Next cycle rsp_valid=1, rsp_data=0x0000_0010, rsp_id=0.
- Contention: both requesters valid on the first cycle after reset. Requester 0 sends SRL 0xF000_0000 shamt 28; requester 1 sends SRA 0x8000_0000 shamt 31.
  - First result: rsp_id=0, rsp_data=0x0000_000F.
  - Next cycle: rsp_id=1, rsp_data=0xFFFF_FFFF.
- Backpressure: rsp_ready=0 for 5 cycles with a pending result 0x1234_5678 (op 11) → rsp_valid and rsp_data hold, and req_ready=00 throughout. Raising rsp_ready → that cycle accepts the next request.
- Reset mid-operation: assert rst while rsp_valid=1 → rsp_valid drops without waiting for a clock edge. After release, requester 0 wins the first contention.
- Counter check (macro defined): 70000 consecutive requester-1 accepts → grant_cnt1=0xFFFF and grant_cnt0=0.

Source files
------------

// File: rtl/shift_arbiter_if.sv
// shift_arbiter_if: request/response bundle for shift_arbiter.
//   req_valid[1:0]   requester -> arbiter, bit i belongs to requester i
//   req_ready[1:0]   arbiter -> requester, accept (at most one bit high)
//   reqX_data/shamt/op  requester X operand, shift amount, operation
//   rsp_valid/rsp_data/rsp_id  arbiter -> consumer, tagged result
//   rsp_ready        consumer -> arbiter, response accept
// Handshake: a transfer happens on the rising clk edge where valid and
// ready are both high; a sender holds valid and payload stable until then.
interface shift_arbiter_if;
  localparam int N = 32;

  logic [1:0]   req_valid;
  logic [1:0]   req_ready;
  logic [N-1:0] req0_data;
  logic [N-1:0] req1_data;
  logic [4:0]   req0_shamt;
  logic [4:0]   req1_shamt;
  logic [1:0]   req0_op;
  logic [1:0]   req1_op;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [N-1:0] rsp_data;
  logic         rsp_id;

  modport master (
    output req_valid, req0_data, req1_data, req0_shamt, req1_shamt,
           req0_op, req1_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req0_data, req1_data, req0_shamt, req1_shamt,
           req0_op, req1_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one 32-bit shift unit (SLL, SRL, SRA, pass) between
// two requesters with round-robin arbitration and a single-entry tagged
// response register with backpressure.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   bus        shift_arbiter_if.slave (request and response channels)
//   state_dbg  current FSM state (0 EMPTY, 1 FULL)
//   grant_cnt0/grant_cnt1  saturating accept counters, only when the
//              macro SHIFT_ARB_GRANT_COUNT_EN is defined
module shift_arbiter (
  input  logic              clk,
  input  logic              rst,
  shift_arbiter_if.slave    bus,
  output logic              state_dbg
`ifdef SHIFT_ARB_GRANT_COUNT_EN
  ,
  output logic [15:0]       grant_cnt0,
  output logic [15:0]       grant_cnt1
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        last_id;
  logic        free;
  logic        winner;
  logic [1:0]  ready;
  logic        accept;
  logic [31:0] sel_data;
  logic [4:0]  sel_shamt;
  logic [1:0]  sel_op;
  logic [31:0] shift_res;
  logic [31:0] rsp_data_q;
  logic        rsp_id_q;

  // Arbitration and next state. Ready is gated by rst so nothing is
  // offered while reset is held.
  always_comb begin
    free      = (state == EMPTY) | bus.rsp_ready;
    ready     = 2'b00;
    winner    = 1'b0;
    state_nxt = state;
    if (!rst && free) begin
      case (bus.req_valid)
        2'b01: begin
          ready  = 2'b01;
          winner = 1'b0;
        end
        2'b10: begin
          ready  = 2'b10;
          winner = 1'b1;
        end
        2'b11: begin
          // The requester not granted last time wins.
          winner = ~last_id;
          ready  = winner ? 2'b10 : 2'b01;
        end
        default: begin
          ready  = 2'b00;
          winner = 1'b0;
        end
      endcase
    end
    accept = |ready;
    if (accept) begin
      state_nxt = FULL;
    end else if ((state == FULL) && bus.rsp_ready) begin
      state_nxt = EMPTY;
    end
  end

  // Shared shift unit fed by the winning requester.
  always_comb begin
    sel_data  = winner ? bus.req1_data  : bus.req0_data;
    sel_shamt = winner ? bus.req1_shamt : bus.req0_shamt;
    sel_op    = winner ? bus.req1_op    : bus.req0_op;
    shift_res = sel_data;
    case (sel_op)
      2'b00:   shift_res = sel_data << sel_shamt;
      2'b01:   shift_res = sel_data >> sel_shamt;
      2'b10:   shift_res = $unsigned($signed(sel_data) >>> sel_shamt);
      default: shift_res = sel_data;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Result register loads only on accept, so data/id hold through drain
  // and while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_data_q <= 32'h0;
      rsp_id_q   <= 1'b0;
      last_id    <= 1'b1;
    end else if (accept) begin
      rsp_data_q <= shift_res;
      rsp_id_q   <= winner;
      last_id    <= winner;
    end
  end

`ifdef SHIFT_ARB_GRANT_COUNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt0 <= 16'h0;
      grant_cnt1 <= 16'h0;
    end else begin
      if (ready[0] && (grant_cnt0 != 16'hFFFF)) begin
        grant_cnt0 <= grant_cnt0 + 16'h1;
      end
      if (ready[1] && (grant_cnt1 != 16'hFFFF)) begin
        grant_cnt1 <= grant_cnt1 + 16'h1;
      end
    end
  end
`endif

  assign bus.req_ready = ready;
  assign bus.rsp_valid = (state == FULL);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign state_dbg     = (state == FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
// tb_shift_arbiter: directed bench for shift_arbiter with a reference
// model checked every cycle on the falling edge.
module tb_shift_arbiter;

  logic clk;
  logic rst;
  logic state_dbg;
`ifdef SHIFT_ARB_GRANT_COUNT_EN
  logic [15:0] grant_cnt0;
  logic [15:0] grant_cnt1;
`endif

  int checks   = 0;
  int failures = 0;

  shift_arbiter_if bus ();

  shift_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
`ifdef SHIFT_ARB_GRANT_COUNT_EN
    ,
    .grant_cnt0(grant_cnt0),
    .grant_cnt1(grant_cnt1)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Shift semantics from plain arithmetic: multiply / floor-divide by 2^s.
  function automatic logic [31:0] ref_shift(input logic [31:0] d,
                                            input logic [4:0] s,
                                            input logic [1:0] op);
    longint p;
    longint u;
    longint sd;
    longint r;
    p  = 1;
    for (int k = 0; k < int'(s); k++) p = p * 2;
    u  = longint'({32'h0, d});
    sd = longint'($signed(d));
    case (op)
      2'b00:   r = u * p;
      2'b01:   r = u / p;
      2'b10:   r = (sd < 0) ? (sd - (p - 1)) / p : sd / p;
      default: r = u;
    endcase
    return r[31:0];
  endfunction

  // ---------------- reference model + compare process ----------------
  logic        m_valid;
  logic [31:0] m_data;
  int          m_id;
  int          m_last;
  int          m_cnt0;
  int          m_cnt1;

  initial begin
    m_valid = 1'b0; m_data = 32'h0; m_id = 0; m_last = 1;
    m_cnt0 = 0; m_cnt1 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_valid = 1'b0; m_data = 32'h0; m_id = 0; m_last = 1;
        m_cnt0 = 0; m_cnt1 = 0;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_data", bus.rsp_data, 32'h0);
        check("rst_rsp_id", 32'(bus.rsp_id), 32'h0);
      end else begin
        int win;
        logic [1:0] exp_ready;
        win = -1;
        if (!m_valid || bus.rsp_ready) begin
          if (bus.req_valid == 2'b11) win = 1 - m_last;
          else if (bus.req_valid[0])  win = 0;
          else if (bus.req_valid[1])  win = 1;
        end
        exp_ready = (win < 0) ? 2'b00 : ((win == 1) ? 2'b10 : 2'b01);
        check("cyc_req_ready", 32'(bus.req_ready), 32'(exp_ready));
        check("cyc_rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
        check("cyc_rsp_data", bus.rsp_data, m_data);
        check("cyc_rsp_id", 32'(bus.rsp_id), 32'(m_id));
        check("cyc_state_dbg", 32'(state_dbg), 32'(m_valid));
`ifdef SHIFT_ARB_GRANT_COUNT_EN
        check("cyc_cnt0", 32'(grant_cnt0), 32'(m_cnt0));
        check("cyc_cnt1", 32'(grant_cnt1), 32'(m_cnt1));
`endif
        // Advance the model to the state after the next rising edge.
        if (win >= 0) begin
          if (win == 0) m_data = ref_shift(bus.req0_data, bus.req0_shamt, bus.req0_op);
          else          m_data = ref_shift(bus.req1_data, bus.req1_shamt, bus.req1_op);
          m_id    = win;
          m_last  = win;
          m_valid = 1'b1;
          if (win == 0 && m_cnt0 < 65535) m_cnt0++;
          if (win == 1 && m_cnt1 < 65535) m_cnt1++;
        end else if (m_valid && bus.rsp_ready) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [31:0] d,
                         input logic [4:0] s, input logic [1:0] op);
    if (i == 0) begin
      bus.req_valid[0] = v; bus.req0_data = d; bus.req0_shamt = s; bus.req0_op = op;
    end else begin
      bus.req_valid[1] = v; bus.req1_data = d; bus.req1_shamt = s; bus.req1_op = op;
    end
  endtask

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[7];

  // ---------------- stimulus ----------------
  initial begin
    vecs[0] = '{1, 32'h8000_0001, 5'd1,  2'b00, 32'h0000_0002};
    vecs[1] = '{0, 32'h7FFF_FFFF, 5'd4,  2'b10, 32'h07FF_FFFF};
    vecs[2] = '{1, 32'hDEAD_BEEF, 5'd0,  2'b10, 32'hDEAD_BEEF};
    vecs[3] = '{0, 32'hCAFE_F00D, 5'd17, 2'b11, 32'hCAFE_F00D};
    vecs[4] = '{1, 32'h8000_0000, 5'd31, 2'b01, 32'h0000_0001};
    vecs[5] = '{0, 32'h9000_0000, 5'd4,  2'b10, 32'hF900_0000};
    vecs[6] = '{1, 32'hFFFF_FFFF, 5'd31, 2'b00, 32'h8000_0000};

    rst = 1'b1;
    bus.req_valid = 2'b00;
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    bus.rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Reset then idle.
    @(negedge clk);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("idle_rsp_data", bus.rsp_data, 32'h0);
    check("idle_req_ready", 32'(bus.req_ready), 32'h0);

    // Single request.
    tick();
    set_req(0, 1'b1, 32'h0000_0001, 5'd4, 2'b00);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("single_req_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    @(negedge clk);
    check("single_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("single_rsp_data", bus.rsp_data, 32'h0000_0010);
    check("single_rsp_id", 32'(bus.rsp_id), 32'h0);

    // Contention on the first cycle after reset.
    tick();
    rst = 1'b1;
    tick();
    tick();
    set_req(0, 1'b1, 32'hF000_0000, 5'd28, 2'b01);
    set_req(1, 1'b1, 32'h8000_0000, 5'd31, 2'b10);
    rst = 1'b0;
    @(negedge clk);
    check("cont_first_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    @(negedge clk);
    check("cont_id0", 32'(bus.rsp_id), 32'h0);
    check("cont_data0", bus.rsp_data, 32'h0000_000F);
    check("cont_second_ready", 32'(bus.req_ready), 32'h2);
    tick();
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    @(negedge clk);
    check("cont_id1", 32'(bus.rsp_id), 32'h1);
    check("cont_data1", bus.rsp_data, 32'hFFFF_FFFF);

    // Back-to-back alternation with both requesters held valid.
    tick();
    set_req(0, 1'b1, 32'h0000_00F0, 5'd4, 2'b01);
    set_req(1, 1'b1, 32'h0000_00F0, 5'd4, 2'b00);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("b2b_ready", 32'(bus.req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      tick();
    end
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    tick();

    // Backpressure with a pass-through result pending.
    bus.rsp_ready = 1'b0;
    set_req(0, 1'b1, 32'h1234_5678, 5'd9, 2'b11);
    @(negedge clk);
    check("bp_first_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b1, 32'h0000_000A, 5'd1, 2'b00);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold_valid", 32'(bus.rsp_valid), 32'h1);
      check("bp_hold_data", bus.rsp_data, 32'h1234_5678);
      check("bp_hold_ready", 32'(bus.req_ready), 32'h0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_next_data", bus.rsp_data, 32'h0000_0014);

    // Reset mid-operation, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.rsp_valid), 32'h0);
    tick();
    tick();
    set_req(0, 1'b1, 32'h0000_0003, 5'd1, 2'b00);
    set_req(1, 1'b1, 32'h0000_0003, 5'd1, 2'b01);
    bus.rsp_ready = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'h1);
    tick();
    set_req(0, 1'b0, 32'h0, 5'd0, 2'b00);
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    @(negedge clk);
    check("post_rst_id", 32'(bus.rsp_id), 32'h0);
    check("post_rst_data", bus.rsp_data, 32'h0000_0006);
    tick();

    // Directed shift vectors, with a short stall before each.
    foreach (vecs[v]) begin
      bit got;
      got = 1'b0;
      set_req(vecs[v].id, 1'b1, vecs[v].data, vecs[v].shamt, vecs[v].op);
      for (int t = 0; t < 20 && !got; t++) begin
        bus.rsp_ready = (t >= v % 3);
        @(negedge clk);
        if (bus.req_ready[vecs[v].id]) got = 1'b1;
        tick();
      end
      set_req(vecs[v].id, 1'b0, 32'h0, 5'd0, 2'b00);
      bus.rsp_ready = 1'b0;
      check("vec_accepted", 32'(got), 32'h1);
      @(negedge clk);
      check("vec_data", bus.rsp_data, vecs[v].exp);
      check("vec_id", 32'(bus.rsp_id), 32'(vecs[v].id));
      tick();
      bus.rsp_ready = 1'b1;
      tick();
    end

`ifdef SHIFT_ARB_GRANT_COUNT_EN
    // Counter saturation.
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_req(1, 1'b1, 32'h0000_0001, 5'd1, 2'b00);
    repeat (70000) tick();
    set_req(1, 1'b0, 32'h0, 5'd0, 2'b00);
    @(negedge clk);
    check("sat_cnt1", 32'(grant_cnt1), 32'h0000_FFFF);
    check("sat_cnt0", 32'(grant_cnt0), 32'h0);
`endif

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
